// File: rtl/bdd_sram_pkg.sv
// bdd_sram_pkg: shared widths, requester id, SRAM command and lock-state types
// for the BDD node SRAM arbiter.
package bdd_sram_pkg;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 48;
    localparam int MAX_REQ = 8;
    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;
    typedef struct packed {
        logic write;
        logic read;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } sram_cmd_t;
    typedef enum logic {FREE, LOCKED} lock_state_t;
    function automatic req_id_t next_id(input req_id_t id, input int n);
        return (int'(id) == n - 1) ? '0 : id + req_id_t'(1);
    endfunction
endpackage

// File: rtl/bdd_sram_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant from a registered pointer; pointer moves past
// the winner after every grant and holds when idle.
module rr_arbiter import bdd_sram_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output req_id_t            id
);
    req_id_t ptr;
    int idx;
    // Scan offsets high to low so the requester closest to ptr wins.
    always_comb begin
        grant = '0;
        id = '0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (valid[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
                id = req_id_t'(idx);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (|grant)
            ptr <= next_id(id, NUM_REQ);
    end
endmodule

// File: rtl/bdd_sram_arbiter.sv
// bdd_sram_arbiter: shares one single-port node SRAM among NUM_REQ BDD engines.
// Optional BDD_SRAM_ARB_LOCK_EN adds i_req_lock for atomic multi-access ownership.
module bdd_sram_arbiter import bdd_sram_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_write,
`ifdef BDD_SRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            i_req_lock,
`endif
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_sram_write,
    output logic                          o_sram_read,
    output logic [ADDR_WIDTH-1:0]         o_sram_addr,
    output logic [DATA_WIDTH-1:0]         o_sram_data,
    input  logic [DATA_WIDTH-1:0]         i_sram_data
);
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    req_id_t gid;
    req_id_t s1_id;
    req_id_t s2_id;
    logic accept;
    logic sel_write;
    logic s1_read;
    logic s2_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
`ifdef BDD_SRAM_ARB_LOCK_EN
    lock_state_t state;
    req_id_t owner;
    logic sel_lock;
    always_comb begin
        eligible = i_req_valid;
        for (int k = 0; k < NUM_REQ; k++)
            if (state == LOCKED && owner != req_id_t'(k))
                eligible[k] = 1'b0;
    end
    always_comb begin
        sel_lock = 1'b0;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant[k])
                sel_lock = i_req_lock[k];
    end
    // While LOCKED only the owner is eligible, so any accept here is the owner's.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FREE;
            owner <= '0;
        end else if (accept) begin
            state <= sel_lock ? LOCKED : FREE;
            owner <= gid;
        end
    end
`else
    assign eligible = i_req_valid;
`endif
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk(i_clk),
        .rst(i_rst),
        .valid(eligible),
        .grant(grant),
        .id(gid)
    );
    assign o_req_ready = grant;
    assign accept = |grant;
    always_comb begin
        sel_write = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant[k]) begin
                sel_write = i_req_write[k];
                sel_addr = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
    end
    // Stage1 mirrors the issued read; stage2 lines up with SRAM read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sram_write <= 1'b0;
            o_sram_read <= 1'b0;
            o_sram_addr <= '0;
            o_sram_data <= '0;
            s1_read <= 1'b0;
            s1_id <= '0;
            s2_valid <= 1'b0;
            s2_id <= '0;
        end else begin
            o_sram_write <= accept & sel_write;
            o_sram_read <= accept & ~sel_write;
            if (accept) begin
                o_sram_addr <= sel_addr;
                o_sram_data <= sel_data;
            end
            s1_read <= accept & ~sel_write;
            s1_id <= gid;
            s2_valid <= s1_read;
            s2_id <= s1_id;
        end
    end
    always_comb begin
        o_rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++)
            o_rsp_valid[k] = s2_valid && (s2_id == req_id_t'(k));
    end
    assign o_rsp_data = i_sram_data;
endmodule

// File: tb/tb_bdd_sram_arbiter.sv
// tb_bdd_sram_arbiter: directed stimulus with a response scoreboard and a
// behavioural 1-cycle-read SRAM behind the arbiter.
module tb_bdd_sram_arbiter;
    localparam int N = 4;
    localparam int AW = 5;
    localparam int DW = 48;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_write = '0;
`ifdef BDD_SRAM_ARB_LOCK_EN
    logic [N-1:0] req_lock = '0;
`endif
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] rsp_valid;
    logic [DW-1:0] rsp_data;
    logic sram_write;
    logic sram_read;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] mem [32];
    logic loaded = 1'b0;
    int checks = 0;
    int errors = 0;
    typedef struct packed {
        logic [N-1:0] who;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];
    logic [DW-1:0] dtab [4] = '{48'hC0DE_0000_0000, 48'hC0DE_0000_0008,
                                48'hC0DE_0000_0010, 48'hC0DE_0000_0018};

    always #5 clk = ~clk;

    bdd_sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_valid(req_valid),
        .i_req_write(req_write),
`ifdef BDD_SRAM_ARB_LOCK_EN
        .i_req_lock(req_lock),
`endif
        .i_req_addr(req_addr),
        .i_req_wdata(req_wdata),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data),
        .o_sram_write(sram_write),
        .o_sram_read(sram_read),
        .o_sram_addr(sram_addr),
        .o_sram_data(sram_wdata),
        .i_sram_data(sram_rdata)
    );

    // Each word preloads to C0DE_0000_00aa so read data identifies its address.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 32; a++)
                mem[a] <= {16'hC0DE, 27'd0, 5'(a)};
            loaded <= 1'b1;
        end else if (sram_write)
            mem[sram_addr] <= sram_wdata;
        if (sram_read)
            sram_rdata <= mem[sram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    rsp_t e;
    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            if (exp_q.size() == 0)
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_who", 64'(rsp_valid), 64'(e.who));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
            end
        end
    end

    task automatic set_req(input int k, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k] = v;
        req_write[k] = w;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic issue(input string name, input logic [N-1:0] exp_grant,
                         input logic [DW-1:0] exp_data);
        rsp_t r;
        @(negedge clk);
        chk(name, 64'(req_ready), 64'(exp_grant));
        if (exp_grant != '0 && (exp_grant & req_write) == '0) begin
            r.who = exp_grant;
            r.data = exp_data;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sram_write", 64'(sram_write), 64'd0);
        chk("rst_sram_read", 64'(sram_read), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("rst_sram_data", 64'(sram_wdata), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        // Write then read back through requester 0.
        set_req(0, 1'b1, 1'b1, 5'd3, 48'hA5A5_0000_0001);
        issue("t1_wr_grant", 4'b0001, '0);
        chk("t1_sram_write", 64'(sram_write), 64'd1);
        chk("t1_sram_addr", 64'(sram_addr), 64'd3);
        chk("t1_sram_data", 64'(sram_wdata), 64'hA5A5_0000_0001);
        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        issue("t1_rd_grant", 4'b0001, 48'hA5A5_0000_0001);
        chk("t1_sram_read", 64'(sram_read), 64'd1);
        chk("t1_sram_rd_nowrite", 64'(sram_write), 64'd0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        repeat (3) issue("idle_grant", 4'b0000, '0);
        chk("idle_read", 64'(sram_read), 64'd0);
        chk("idle_write", 64'(sram_write), 64'd0);
        chk("idle_addr_hold", 64'(sram_addr), 64'd3);
        // Reset the cycle after a read accept: its response must vanish.
        set_req(1, 1'b1, 1'b0, 5'd5, '0);
        @(negedge clk);
        chk("rst_mid_grant", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_read", 64'(sram_read), 64'd0);
        chk("rst_mid_write", 64'(sram_write), 64'd0);
        chk("rst_mid_addr", 64'(sram_addr), 64'd0);
        // All four reading: grants start at req0 after reset.
        for (int k = 0; k < N; k++)
            set_req(k, 1'b1, 1'b0, 5'(8 * k), '0);
        for (int i = 0; i < 7; i++)
            issue("rr_grant", 4'(1 << (i % 4)), dtab[i % 4]);
        // Pointer is now 3 with only req0 and req3 left.
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b0, 1'b0, '0, '0);
        issue("wrap_grant0", 4'b1000, dtab[3]);
        issue("wrap_grant1", 4'b0001, dtab[0]);
        issue("wrap_grant2", 4'b1000, dtab[3]);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b0, 1'b0, '0, '0);
        // Read immediately after a write to the same address sees new data.
        set_req(1, 1'b1, 1'b1, 5'd31, 48'h1234_5678_9ABC);
        issue("wr31_grant", 4'b0010, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b1, 1'b0, 5'd31, '0);
        issue("rd31_grant", 4'b0100, 48'h1234_5678_9ABC);
        chk("rd31_sram_read", 64'(sram_read), 64'd1);
        chk("rd31_sram_addr", 64'(sram_addr), 64'd31);
        set_req(2, 1'b0, 1'b0, '0, '0);
        repeat (3) issue("idle_grant", 4'b0000, '0);
`ifdef BDD_SRAM_ARB_LOCK_EN
        set_req(1, 1'b1, 1'b0, 5'd8, '0);
        issue("lk_pre_grant", 4'b0010, dtab[1]);
        set_req(0, 1'b1, 1'b0, 5'd0, '0);
        set_req(2, 1'b1, 1'b0, 5'd31, '0);
        req_lock[2] = 1'b1;
        issue("lk0_grant", 4'b0100, 48'h1234_5678_9ABC);
        issue("lk1_grant", 4'b0100, 48'h1234_5678_9ABC);
        req_lock[2] = 1'b0;
        issue("lk2_grant", 4'b0100, 48'h1234_5678_9ABC);
        set_req(2, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b1, 1'b0, 5'd24, '0);
        issue("lk3_grant", 4'b1000, dtab[3]);
        issue("lk4_grant", 4'b0001, dtab[0]);
        for (int k = 0; k < N; k++)
            set_req(k, 1'b0, 1'b0, '0, '0);
`endif
        repeat (4) issue("drain_grant", 4'b0000, '0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
